if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch initiator for the pipelined MIPS core. It owns the PC, drives a word address into the combinational instruction ROM, and captures the returned word into the IF/ID pipeline register. It handles stall, EX-stage redirect (branch/flush) and early decode of J/JAL with zero delay slots. It also keeps a sticky misalignment flag and a fetch counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned).
EARLY_JUMP, 1, 1 = decode opcode 2/3 in IF and redirect; 0 = always sequential unless redirected.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  hazard unit hold; freezes PC and IF/ID
redirect  input  1  EX-stage taken branch/jump-register; squashes the current fetch
redirect_target  input  32  new PC when redirect=1
imem_addr  output  32  address to instruction ROM (= PC register, combinational)
imem_data  input  32  instruction word from ROM, valid same cycle
if_id_instr  output  32  registered instruction
if_id_pc4  output  32  registered PC+4 of that instruction
if_id_valid  output  1  1 = if_id_instr is a real fetched instruction
misalign_err  output  1  sticky: a misaligned redirect target was seen
fetch_count  output  32  count of instructions loaded into IF/ID with valid=1

Behaviour:
- Reset (sync, reset=1 at posedge):
  - pc=RESET_PC; if_id_instr=0 (nop); if_id_pc4=0; if_id_valid=0; misalign_err=0; fetch_count=0.
  - reset overrides every other input.
- imem_addr = pc at all times. Fetch latency is zero cycles to ROM data and one cycle to IF/ID.
- pc4 = pc + 32'd4, modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- jump_hit = EARLY_JUMP && (imem_data[31:26]==6'd2 || imem_data[31:26]==6'd3).
- jump_tgt = {pc4[31:28], imem_data[25:0], 2'b00}.
- Per posedge, priority redirect > stall > jump_hit > sequential:
  - redirect=1:
    - pc <= {redirect_target[31:2],2'b00}.
    - IF/ID <= bubble (instr=0, pc4=0, valid=0). The wrong-path word is discarded.
    - fetch_count unchanged.
    - If redirect_target[1:0]!=0, misalign_err <= 1.
    - Applies even when stall=1.
  - stall=1, redirect=0:
    - pc, IF/ID and fetch_count hold.
    - jump_hit is ignored; it is re-evaluated when the stall releases because imem_addr is unchanged.
  - jump_hit (no stall, no redirect):
    - IF/ID <= {imem_data, pc4, 1}. The J/JAL itself enters the pipe so JAL can link pc4.
    - pc <= jump_tgt. No delay-slot instruction is fetched.
    - fetch_count++.
  - sequential:
    - IF/ID <= {imem_data, pc4, 1}; pc <= pc4; fetch_count++.
- fetch_count wraps from 32'hFFFF_FFFF to 0.
- misalign_err is cleared only by reset.
- X handling: if imem_data contains X while loading IF/ID (unmapped ROM word), load it unchanged. No internal check is made; X propagation is the verifier's observable.
- No combinational path from stall/redirect to imem_addr. imem_addr depends only on the pc register.
- Reset mid-stall or mid-redirect: reset wins. The next cycle fetches RESET_PC with if_id_valid=0.

Test Plan:
1. Reset 2 cycles, then run with standard ROM image (lw at 0, add at 4, j 7 at 8, add at 12, nops 16-24, add at 28, 32):
   - imem_addr sequence 0,4,8,28,32.
   - IF/ID instr sequence 8C02_0004, 0042_1020, 0800_0007, 0042_1020, 0042_1020.
   - Address 12 is never presented; fetch_count=5.
2. Stall asserted 3 cycles while pc=4:
   - imem_addr stays 4; if_id_instr holds 8C02_0004; fetch_count frozen.
   - On release, next IF/ID = 0042_1020 with pc4=8.
3. redirect=1, target=32'h10, with stall=1 at pc=8:
   - Next cycle pc=16, if_id_valid=0, if_id_instr=0.
   - The J at 8 is not taken; misalign_err stays 0.
4. redirect to 32'h1E:
   - pc=32'h1C, misalign_err=1.
   - misalign_err stays 1 through later redirects; cleared only after reset=1.
5. EARLY_JUMP=0 with same image: imem_addr sequence 0,4,8,12,16; the J word is delivered to IF/ID with valid=1.
6. Wrap and mid-operation reset:
   - Redirect to 32'hFFFF_FFFC, run 1 cycle: pc=0 and if_id_pc4=0.
   - Assert reset mid-run: all outputs return to their reset values on that edge.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction ROM
// and loads the IF/ID pipeline register, with stall, EX redirect and early J/JAL decode.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter bit          EARLY_JUMP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc4;
  logic [31:0] jump_tgt;
  logic        jump_hit;

  // imem_addr comes straight from the PC register, so stall/redirect never reach the ROM combinationally
  assign imem_addr = pc_q;
  assign pc4       = pc_q + 32'd4;
  assign jump_tgt  = {pc4[31:28], imem_data[25:0], 2'b00};
  assign jump_hit  = EARLY_JUMP && ((imem_data[31:26] == 6'd2) || (imem_data[31:26] == 6'd3));

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
    count_d    = count_q;
    if (redirect) begin
      pc_d    = {redirect_target[31:2], 2'b00};
      instr_d = 32'd0;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
      if (redirect_target[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else if (!stall) begin
      // The J/JAL itself enters IF/ID so JAL can still link its pc4
      instr_d = imem_data;
      pc4_d   = pc4;
      valid_d = 1'b1;
      count_d = count_q + 32'd1;
      pc_d    = jump_hit ? jump_tgt : pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      pc4_q      <= 32'd0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign if_id_instr  = instr_q;
  assign if_id_pc4    = pc4_q;
  assign if_id_valid  = valid_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: one instance with early jump decode, one without,
// both fed from the same small ROM image.
module tb_if_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectTarget = 32'd0;

  logic [31:0] addrA, dataA, instrA, pc4A, countA;
  logic        validA, misA;
  logic [31:0] addrB, dataB, instrB, pc4B, countB;
  logic        validB, misB;

  int checkCount = 0;
  int errorCount = 0;

  // ROM image: lw, add, j 7, add, nops, add at 28 and 32, jal 5 at 0x40
  function automatic logic [31:0] romWord(input logic [31:0] a);
    case (a)
      32'h00:         romWord = 32'h8C02_0004;
      32'h04:         romWord = 32'h0042_1020;
      32'h08:         romWord = 32'h0800_0007;
      32'h0C:         romWord = 32'h0042_1020;
      32'h1C, 32'h20: romWord = 32'h0042_1020;
      32'h40:         romWord = 32'h0C00_0005;
      default:        romWord = 32'h0000_0000;
    endcase
  endfunction

  assign dataA = romWord(addrA);
  assign dataB = romWord(addrB);

  if_fetch_unit #(.RESET_PC(32'h0), .EARLY_JUMP(1'b1)) dutA (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirectTarget), .imem_addr(addrA), .imem_data(dataA),
    .if_id_instr(instrA), .if_id_pc4(pc4A), .if_id_valid(validA),
    .misalign_err(misA), .fetch_count(countA)
  );

  if_fetch_unit #(.RESET_PC(32'h0), .EARLY_JUMP(1'b0)) dutB (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirectTarget), .imem_addr(addrB), .imem_data(dataB),
    .if_id_instr(instrB), .if_id_pc4(pc4B), .if_id_valid(validB),
    .misalign_err(misB), .fetch_count(countB)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirectTarget = 32'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checkCount++; if (addrA !== 32'h0) begin errorCount++; $display("[TB] FAIL reset_addr got %h want %h", addrA, 32'h0); end
    checkCount++; if (instrA !== 32'h0) begin errorCount++; $display("[TB] FAIL reset_instr got %h want %h", instrA, 32'h0); end
    checkCount++; if (pc4A !== 32'h0) begin errorCount++; $display("[TB] FAIL reset_pc4 got %h want %h", pc4A, 32'h0); end
    checkCount++; if (validA !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_valid got %b want 0", validA); end
    checkCount++; if (misA !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_misalign got %b want 0", misA); end
    checkCount++; if (countA !== 32'h0) begin errorCount++; $display("[TB] FAIL reset_count got %h want %h", countA, 32'h0); end
  endtask

  task automatic test_sequential_jump();
    logic [31:0] expAddr[5];
    logic [31:0] expInstr[5];
    logic [31:0] expPc4[5];
    logic        sawTwelve;
    expAddr  = '{32'h00, 32'h04, 32'h08, 32'h1C, 32'h20};
    expInstr = '{32'h8C02_0004, 32'h0042_1020, 32'h0800_0007, 32'h0042_1020, 32'h0042_1020};
    expPc4   = '{32'h04, 32'h08, 32'h0C, 32'h20, 32'h24};
    sawTwelve = 1'b0;
    doReset();
    for (int i = 0; i < 5; i++) begin
      if (addrA === 32'h0C) sawTwelve = 1'b1;
      checkCount++; if (addrA !== expAddr[i]) begin errorCount++; $display("[TB] FAIL seq_addr[%0d] got %h want %h", i, addrA, expAddr[i]); end
      tick();
      checkCount++; if (instrA !== expInstr[i]) begin errorCount++; $display("[TB] FAIL seq_instr[%0d] got %h want %h", i, instrA, expInstr[i]); end
      checkCount++; if (pc4A !== expPc4[i]) begin errorCount++; $display("[TB] FAIL seq_pc4[%0d] got %h want %h", i, pc4A, expPc4[i]); end
    end
    checkCount++; if (sawTwelve !== 1'b0) begin errorCount++; $display("[TB] FAIL seq_skip12 got %b want 0", sawTwelve); end
    checkCount++; if (countA !== 32'd5) begin errorCount++; $display("[TB] FAIL seq_count got %0d want 5", countA); end
  endtask

  task automatic test_stall();
    doReset();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkCount++; if (addrA !== 32'h04) begin errorCount++; $display("[TB] FAIL stall_addr[%0d] got %h want %h", i, addrA, 32'h04); end
      checkCount++; if (instrA !== 32'h8C02_0004) begin errorCount++; $display("[TB] FAIL stall_instr[%0d] got %h want %h", i, instrA, 32'h8C02_0004); end
      checkCount++; if (countA !== 32'd1) begin errorCount++; $display("[TB] FAIL stall_count[%0d] got %0d want 1", i, countA); end
    end
    stall = 1'b0;
    tick();
    checkCount++; if (instrA !== 32'h0042_1020) begin errorCount++; $display("[TB] FAIL release_instr got %h want %h", instrA, 32'h0042_1020); end
    checkCount++; if (pc4A !== 32'h08) begin errorCount++; $display("[TB] FAIL release_pc4 got %h want %h", pc4A, 32'h08); end
  endtask

  // Continues from pc=8 left by test_stall
  task automatic test_redirect_stall();
    stall = 1'b1;
    tick();
    checkCount++; if (addrA !== 32'h08) begin errorCount++; $display("[TB] FAIL stalljump_addr got %h want %h", addrA, 32'h08); end
    checkCount++; if (countA !== 32'd2) begin errorCount++; $display("[TB] FAIL stalljump_count got %0d want 2", countA); end
    redirect = 1'b1;
    redirectTarget = 32'h10;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    checkCount++; if (addrA !== 32'h10) begin errorCount++; $display("[TB] FAIL redir_addr got %h want %h", addrA, 32'h10); end
    checkCount++; if (validA !== 1'b0) begin errorCount++; $display("[TB] FAIL redir_valid got %b want 0", validA); end
    checkCount++; if (instrA !== 32'h0) begin errorCount++; $display("[TB] FAIL redir_instr got %h want %h", instrA, 32'h0); end
    checkCount++; if (pc4A !== 32'h0) begin errorCount++; $display("[TB] FAIL redir_pc4 got %h want %h", pc4A, 32'h0); end
    checkCount++; if (countA !== 32'd2) begin errorCount++; $display("[TB] FAIL redir_count got %0d want 2", countA); end
    checkCount++; if (misA !== 1'b0) begin errorCount++; $display("[TB] FAIL redir_misalign got %b want 0", misA); end
  endtask

  task automatic test_misalign();
    redirect = 1'b1;
    redirectTarget = 32'h1E;
    tick();
    redirect = 1'b0;
    checkCount++; if (addrA !== 32'h1C) begin errorCount++; $display("[TB] FAIL mis_addr got %h want %h", addrA, 32'h1C); end
    checkCount++; if (misA !== 1'b1) begin errorCount++; $display("[TB] FAIL mis_set got %b want 1", misA); end
    redirect = 1'b1;
    redirectTarget = 32'h20;
    tick();
    redirect = 1'b0;
    tick();
    checkCount++; if (misA !== 1'b1) begin errorCount++; $display("[TB] FAIL mis_sticky got %b want 1", misA); end
    checkCount++; if (addrA !== 32'h24) begin errorCount++; $display("[TB] FAIL mis_after_addr got %h want %h", addrA, 32'h24); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkCount++; if (misA !== 1'b0) begin errorCount++; $display("[TB] FAIL mis_clear got %b want 0", misA); end
  endtask

  task automatic test_jal();
    doReset();
    redirect = 1'b1;
    redirectTarget = 32'h40;
    tick();
    redirect = 1'b0;
    tick();
    checkCount++; if (instrA !== 32'h0C00_0005) begin errorCount++; $display("[TB] FAIL jal_instr got %h want %h", instrA, 32'h0C00_0005); end
    checkCount++; if (pc4A !== 32'h44) begin errorCount++; $display("[TB] FAIL jal_pc4 got %h want %h", pc4A, 32'h44); end
    checkCount++; if (validA !== 1'b1) begin errorCount++; $display("[TB] FAIL jal_valid got %b want 1", validA); end
    checkCount++; if (addrA !== 32'h14) begin errorCount++; $display("[TB] FAIL jal_addr got %h want %h", addrA, 32'h14); end
    checkCount++; if (countA !== 32'd1) begin errorCount++; $display("[TB] FAIL jal_count got %0d want 1", countA); end
  endtask

  task automatic test_no_early_jump();
    logic [31:0] expAddr[5];
    logic [31:0] expInstr[5];
    expAddr  = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
    expInstr = '{32'h8C02_0004, 32'h0042_1020, 32'h0800_0007, 32'h0042_1020, 32'h0000_0000};
    doReset();
    for (int i = 0; i < 5; i++) begin
      checkCount++; if (addrB !== expAddr[i]) begin errorCount++; $display("[TB] FAIL nojump_addr[%0d] got %h want %h", i, addrB, expAddr[i]); end
      tick();
      checkCount++; if (instrB !== expInstr[i]) begin errorCount++; $display("[TB] FAIL nojump_instr[%0d] got %h want %h", i, instrB, expInstr[i]); end
      checkCount++; if (validB !== 1'b1) begin errorCount++; $display("[TB] FAIL nojump_valid[%0d] got %b want 1", i, validB); end
    end
    checkCount++; if (countB !== 32'd5) begin errorCount++; $display("[TB] FAIL nojump_count got %0d want 5", countB); end
  endtask

  task automatic test_wrap_reset();
    doReset();
    redirect = 1'b1;
    redirectTarget = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    checkCount++; if (addrA !== 32'hFFFF_FFFC) begin errorCount++; $display("[TB] FAIL wrap_top got %h want %h", addrA, 32'hFFFF_FFFC); end
    tick();
    checkCount++; if (addrA !== 32'h0) begin errorCount++; $display("[TB] FAIL wrap_addr got %h want %h", addrA, 32'h0); end
    checkCount++; if (pc4A !== 32'h0) begin errorCount++; $display("[TB] FAIL wrap_pc4 got %h want %h", pc4A, 32'h0); end
    checkCount++; if (validA !== 1'b1) begin errorCount++; $display("[TB] FAIL wrap_valid got %b want 1", validA); end
    tick();
    tick();
    stall = 1'b1;
    redirect = 1'b1;
    redirectTarget = 32'h46;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    checkCount++; if (addrA !== 32'h0) begin errorCount++; $display("[TB] FAIL midreset_addr got %h want %h", addrA, 32'h0); end
    checkCount++; if (instrA !== 32'h0) begin errorCount++; $display("[TB] FAIL midreset_instr got %h want %h", instrA, 32'h0); end
    checkCount++; if (pc4A !== 32'h0) begin errorCount++; $display("[TB] FAIL midreset_pc4 got %h want %h", pc4A, 32'h0); end
    checkCount++; if (validA !== 1'b0) begin errorCount++; $display("[TB] FAIL midreset_valid got %b want 0", validA); end
    checkCount++; if (misA !== 1'b0) begin errorCount++; $display("[TB] FAIL midreset_misalign got %b want 0", misA); end
    checkCount++; if (countA !== 32'h0) begin errorCount++; $display("[TB] FAIL midreset_count got %h want %h", countA, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_sequential_jump();
    test_stall();
    test_redirect_stall();
    test_misalign();
    test_jal();
    test_no_early_jump();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
